// File: rtl/segm7_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// segm7_pkg : shared constants and types for the segm7 serial-link receivers
// Rev 1.0
// ---------------------------------------------------------------------------
package segm7_pkg;

  localparam int COM_WIDTH       = 8;
  localparam int SEG_WIDTH       = 32;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [0:0] {
    ARM_WAIT = 1'b0,
    ARM_DONE = 1'b1
  } arm_state_e;

  // BIT_CNT must hold WIDTH plus headroom to show overshoot before saturating
  function automatic int bcnt_width(input int width);
    return $clog2(width + 1) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/segm7_sr_receiver_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// segm7_sr_receiver_if : SER/SRCLK/RCLK link plus receiver result bus
// Rev 1.0
// ---------------------------------------------------------------------------
interface segm7_sr_receiver_if
  import segm7_pkg::*;
#(
  parameter int WIDTH  = COM_WIDTH,
  parameter int FCNT_W = 16,
  parameter int BCNT_W = bcnt_width(WIDTH)
) ();

  logic              i_ser;
  logic              i_srclk;
  logic              i_rclk;
  logic [WIDTH-1:0]  o_data_out;
  logic              o_data_valid;
  logic              o_frame_err;
  logic [BCNT_W-1:0] o_bit_cnt;
  logic [FCNT_W-1:0] o_frame_cnt;

  modport master (
    output i_ser, i_srclk, i_rclk,
    input  o_data_out, o_data_valid, o_frame_err, o_bit_cnt, o_frame_cnt
  );

  modport slave (
    input  i_ser, i_srclk, i_rclk,
    output o_data_out, o_data_valid, o_frame_err, o_bit_cnt, o_frame_cnt
  );

endinterface
`default_nettype wire

// File: rtl/segm7_sync_edge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// segm7_sync_edge : multi-flop synchroniser with rising-edge detect
// Rev 1.0
// ---------------------------------------------------------------------------
module segm7_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_in,
  output logic      o_level,
  output logic      o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync    <= '0;
      r_level_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_in};
      r_level_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_level_d;

endmodule
`default_nettype wire

// File: rtl/segm7_sr_receiver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// segm7_sr_receiver : oversampling 74HC595-style shift/latch receiver
// Rev 1.0
// ---------------------------------------------------------------------------
module segm7_sr_receiver
  import segm7_pkg::*;
#(
  parameter int WIDTH       = COM_WIDTH,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FCNT_W      = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  segm7_sr_receiver_if.slave bus
);

  localparam int                BCNT_W      = bcnt_width(WIDTH);
  localparam logic [BCNT_W-1:0] C_BCNT_FULL = BCNT_W'(WIDTH);
  localparam logic [BCNT_W-1:0] C_BCNT_MAX  = '1;
  localparam int                ARM_W       = $clog2(SYNC_STAGES + 1);
  localparam logic [ARM_W-1:0]  C_ARM_LAST  = ARM_W'(SYNC_STAGES);

  logic [2:0] w_line_in;
  logic [2:0] w_level;
  logic [2:0] w_rise;

  assign w_line_in = {bus.i_rclk, bus.i_srclk, bus.i_ser};

  // bit 0 = SER, bit 1 = SRCLK, bit 2 = RCLK; all share one delay so SER aligns with SRCLK
  for (genvar g = 0; g < 3; g++) begin : g_sync
    segm7_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .i_in    (w_line_in[g]),
      .o_level (w_level[g]),
      .o_rise  (w_rise[g])
    );
  end

  arm_state_e       r_arm_state;
  arm_state_e       w_arm_state_nxt;
  logic [ARM_W-1:0] r_arm_cnt;
  logic [ARM_W-1:0] w_arm_cnt_nxt;
  logic             w_armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arm_state <= ARM_WAIT;
      r_arm_cnt   <= '0;
    end else begin
      r_arm_state <= w_arm_state_nxt;
      r_arm_cnt   <= w_arm_cnt_nxt;
    end
  end

  // Holds off edges until the chain has flushed any line already high at release
  always_comb begin
    w_arm_state_nxt = r_arm_state;
    w_arm_cnt_nxt   = r_arm_cnt;
    w_armed         = 1'b0;
    case (r_arm_state)
      ARM_WAIT: begin
        if (r_arm_cnt == C_ARM_LAST) begin
          w_arm_state_nxt = ARM_DONE;
        end else begin
          w_arm_cnt_nxt = r_arm_cnt + ARM_W'(1);
        end
      end
      ARM_DONE: begin
        w_armed = 1'b1;
      end
      default: begin
        w_arm_state_nxt = ARM_WAIT;
        w_arm_cnt_nxt   = '0;
      end
    endcase
  end

  logic w_ser_s;
  logic w_shift;
  logic w_latch;

  assign w_ser_s = w_level[0];
  assign w_shift = w_rise[1] & w_armed;
  assign w_latch = w_rise[2] & w_armed;

  logic [WIDTH-1:0]  r_sr;
  logic [WIDTH-1:0]  r_data_out;
  logic              r_data_valid;
  logic              r_frame_err;
  logic [BCNT_W-1:0] r_bit_cnt;
  logic [BCNT_W-1:0] w_bit_cnt_nxt;
  logic [FCNT_W-1:0] r_frame_cnt;

  // A shift coincident with a latch counts as the first bit of the next word
  always_comb begin
    w_bit_cnt_nxt = r_bit_cnt;
    if (w_latch) begin
      w_bit_cnt_nxt = w_shift ? BCNT_W'(1) : '0;
    end else if (w_shift && (r_bit_cnt != C_BCNT_MAX)) begin
      w_bit_cnt_nxt = r_bit_cnt + BCNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr         <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_bit_cnt    <= '0;
      r_frame_cnt  <= '0;
    end else begin
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_bit_cnt    <= w_bit_cnt_nxt;
      if (w_shift) begin
        r_sr <= {r_sr[WIDTH-2:0], w_ser_s};
      end
      if (w_latch) begin
        r_data_out   <= r_sr;
        r_data_valid <= 1'b1;
        r_frame_err  <= (r_bit_cnt != C_BCNT_FULL);
        r_frame_cnt  <= r_frame_cnt + FCNT_W'(1);
      end
    end
  end

  assign bus.o_data_out   = r_data_out;
  assign bus.o_data_valid = r_data_valid;
  assign bus.o_frame_err  = r_frame_err;
  assign bus.o_bit_cnt    = r_bit_cnt;
  assign bus.o_frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire
